// File: rtl/rob_pkg.sv
// Shared types and sizing for the reorder buffer.
// Optional feature macro: ROB_EXCEPTION_EN adds a per-entry exception bit.
package rob_pkg;

   localparam int ROB_SIZE       = 16;
   localparam int ROB_SIZE_WIDTH = $clog2(ROB_SIZE);
   localparam int ARCH_REG_W     = 5;
   localparam int PHY_REG_W      = 7;
   localparam int CNT_W          = ROB_SIZE_WIDTH + 1;

   typedef logic [ROB_SIZE_WIDTH-1:0] rob_tag_t;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic                  branch_op;
      logic [ARCH_REG_W-1:0] arch_rd;
      logic [PHY_REG_W-1:0]  phy_rd;
      logic [PHY_REG_W-1:0]  old_phy_rd;
`ifdef ROB_EXCEPTION_EN
      logic                  exception;
`endif
   } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctr.sv
// Head/tail wrapping pointers plus occupancy count for the reorder buffer.
// Flush (ROB_EXCEPTION_EN builds) returns everything to the empty state.
module rob_ptr_ctr
   import rob_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push_i,
   input  logic                      pop_i,
   input  logic                      flush_i,
   output logic [ROB_SIZE_WIDTH-1:0] head_o,
   output logic [ROB_SIZE_WIDTH-1:0] tail_o,
   output logic [ROB_SIZE_WIDTH:0]   count_o
);

   rob_tag_t         head_q, head_d;
   rob_tag_t         tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) tail_d = tail_q + 1'b1;
         if (pop_i)  head_d = head_q + 1'b1;
         // Push and pop together leave occupancy unchanged.
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign tail_o  = tail_q;
   assign count_o = count_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at tail, mark done on writeback, retire head.
// Optional feature macro: ROB_EXCEPTION_EN (faulting head flushes the whole buffer).
module reorder_buffer
   import rob_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alloc_valid,
   input  logic                      alloc_branch_op,
   input  logic [ARCH_REG_W-1:0]     alloc_arch_rd,
   input  logic [PHY_REG_W-1:0]      alloc_phy_rd,
   input  logic [PHY_REG_W-1:0]      alloc_old_phy_rd,
   output logic [ROB_SIZE_WIDTH-1:0] alloc_tag,
   input  logic                      wb_valid,
   input  logic [ROB_SIZE_WIDTH-1:0] wb_tag,
   input  logic                      wb_exception,
   output logic                      rob_full,
   output logic                      rob_empty,
   output logic                      commit_valid,
   output logic                      commited_branch_op,
   output logic [ROB_SIZE_WIDTH-1:0] commited_branch_tag,
   output logic [ARCH_REG_W-1:0]     commit_arch_rd,
   output logic [PHY_REG_W-1:0]      commit_phy_rd,
   output logic [PHY_REG_W-1:0]      commit_old_phy_rd,
   output logic                      commit_exception
);

   rob_entry_t       entries_q [ROB_SIZE];
   rob_entry_t       entries_d [ROB_SIZE];
   rob_entry_t       head_entry;
   rob_tag_t         head, tail;
   logic [CNT_W-1:0] count;
   logic             alloc_ok;
   logic             flush;

   assign head_entry = entries_q[head];
   assign rob_full   = (count == CNT_W'(ROB_SIZE));
   assign rob_empty  = (count == '0);

`ifdef ROB_EXCEPTION_EN
   assign flush        = head_entry.valid & head_entry.done & head_entry.exception;
   assign commit_valid = head_entry.valid & head_entry.done & ~head_entry.exception;
`else
   logic unused_wb_exception;
   assign unused_wb_exception = wb_exception;
   assign flush        = 1'b0;
   assign commit_valid = head_entry.valid & head_entry.done;
`endif

   // rob_full is from the registered count, so a same-cycle commit cannot free a slot.
   assign alloc_ok  = alloc_valid & ~rob_full & ~flush;
   assign alloc_tag = tail;

   assign commit_exception    = flush;
   assign commited_branch_op  = commit_valid & head_entry.branch_op;
   assign commited_branch_tag = head;
   assign commit_arch_rd      = head_entry.arch_rd;
   assign commit_phy_rd       = head_entry.phy_rd;
   assign commit_old_phy_rd   = head_entry.old_phy_rd;

   rob_ptr_ctr u_ptr (
      .clk     (clk),
      .reset   (reset),
      .push_i  (alloc_ok),
      .pop_i   (commit_valid),
      .flush_i (flush),
      .head_o  (head),
      .tail_o  (tail),
      .count_o (count)
   );

   always_comb begin
      entries_d = entries_q;
      if (wb_valid && entries_q[wb_tag].valid) begin
         entries_d[wb_tag].done = 1'b1;
`ifdef ROB_EXCEPTION_EN
         entries_d[wb_tag].exception = wb_exception;
`endif
      end
      if (commit_valid) entries_d[head] = '0;
      if (alloc_ok) begin
         entries_d[tail].valid      = 1'b1;
         entries_d[tail].done       = 1'b0;
         entries_d[tail].branch_op  = alloc_branch_op;
         entries_d[tail].arch_rd    = alloc_arch_rd;
         entries_d[tail].phy_rd     = alloc_phy_rd;
         entries_d[tail].old_phy_rd = alloc_old_phy_rd;
`ifdef ROB_EXCEPTION_EN
         entries_d[tail].exception  = 1'b0;
`endif
      end
      if (flush) begin
         for (int i = 0; i < ROB_SIZE; i++) entries_d[i] = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROB_SIZE; i++) entries_q[i] <= '0;
      end else begin
         entries_q <= entries_d;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; expected values are hand-computed constants.
// Build with ROB_EXCEPTION_EN defined to include the flush scenario.
module tb_reorder_buffer;
   import rob_pkg::*;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      alloc_valid;
   logic                      alloc_branch_op;
   logic [ARCH_REG_W-1:0]     alloc_arch_rd;
   logic [PHY_REG_W-1:0]      alloc_phy_rd;
   logic [PHY_REG_W-1:0]      alloc_old_phy_rd;
   logic [ROB_SIZE_WIDTH-1:0] alloc_tag;
   logic                      wb_valid;
   logic [ROB_SIZE_WIDTH-1:0] wb_tag;
   logic                      wb_exception;
   logic                      rob_full;
   logic                      rob_empty;
   logic                      commit_valid;
   logic                      commited_branch_op;
   logic [ROB_SIZE_WIDTH-1:0] commited_branch_tag;
   logic [ARCH_REG_W-1:0]     commit_arch_rd;
   logic [PHY_REG_W-1:0]      commit_phy_rd;
   logic [PHY_REG_W-1:0]      commit_old_phy_rd;
   logic                      commit_exception;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk                 (clk),
      .reset               (reset),
      .alloc_valid         (alloc_valid),
      .alloc_branch_op     (alloc_branch_op),
      .alloc_arch_rd       (alloc_arch_rd),
      .alloc_phy_rd        (alloc_phy_rd),
      .alloc_old_phy_rd    (alloc_old_phy_rd),
      .alloc_tag           (alloc_tag),
      .wb_valid            (wb_valid),
      .wb_tag              (wb_tag),
      .wb_exception        (wb_exception),
      .rob_full            (rob_full),
      .rob_empty           (rob_empty),
      .commit_valid        (commit_valid),
      .commited_branch_op  (commited_branch_op),
      .commited_branch_tag (commited_branch_tag),
      .commit_arch_rd      (commit_arch_rd),
      .commit_phy_rd       (commit_phy_rd),
      .commit_old_phy_rd   (commit_old_phy_rd),
      .commit_exception    (commit_exception)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alloc(input logic v, input logic br, input int rd, input int phy, input int old);
      alloc_valid      = v;
      alloc_branch_op  = br;
      alloc_arch_rd    = ARCH_REG_W'(rd);
      alloc_phy_rd     = PHY_REG_W'(phy);
      alloc_old_phy_rd = PHY_REG_W'(old);
   endtask

   task automatic set_wb(input logic v, input int tag);
      wb_valid = v;
      wb_tag   = ROB_SIZE_WIDTH'(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      wb_exception = 1'b0;
      set_alloc(0, 0, 0, 0, 0);
      set_wb(0, 0);
      tick();
      tick();
      check_val("rst_empty", rob_empty, 1);
      check_val("rst_full", rob_full, 0);
      check_val("rst_cvalid", commit_valid, 0);
      check_val("rst_atag", alloc_tag, 0);
      check_val("rst_cexc", commit_exception, 0);
      check_val("rst_crd", commit_arch_rd, 0);
      check_val("rst_cphy", commit_phy_rd, 0);
      check_val("rst_cold", commit_old_phy_rd, 0);
      check_val("rst_cbr", commited_branch_op, 0);
      reset = 1'b0;
      tick();

      // Three allocations, no writeback
      for (int i = 0; i < 3; i++) begin
         set_alloc(1, 0, i + 1, i + 11, i + 21);
         #1;
         check_val($sformatf("t1_atag%0d", i), alloc_tag, i);
         tick();
         check_val($sformatf("t1_cvalid%0d", i), commit_valid, 0);
      end
      set_alloc(0, 0, 0, 0, 0);
      check_val("t1_empty", rob_empty, 0);
      check_val("t1_full", rob_full, 0);
      check_val("t1_atag3", alloc_tag, 3);

      // Out-of-order writeback, in-order commit
      set_wb(1, 2); tick();
      check_val("t2_cv_after_wb2", commit_valid, 0);
      set_wb(1, 1); tick();
      check_val("t2_cv_after_wb1", commit_valid, 0);
      set_wb(1, 0); tick();
      set_wb(0, 0);
      for (int i = 0; i < 3; i++) begin
         check_val($sformatf("t2_cv%0d", i), commit_valid, 1);
         check_val($sformatf("t2_tag%0d", i), commited_branch_tag, i);
         check_val($sformatf("t2_rd%0d", i), commit_arch_rd, i + 1);
         check_val($sformatf("t2_phy%0d", i), commit_phy_rd, i + 11);
         check_val($sformatf("t2_old%0d", i), commit_old_phy_rd, i + 21);
         tick();
      end
      check_val("t2_cv_done", commit_valid, 0);
      check_val("t2_empty", rob_empty, 1);

      // Asynchronous reset while a committable head is present
      set_alloc(1, 0, 9, 19, 29); tick();
      set_alloc(0, 0, 0, 0, 0);
      set_wb(1, 3); tick();
      set_wb(0, 0);
      check_val("rst2_cv_before", commit_valid, 1);
      reset = 1'b1;
      #1;
      check_val("rst2_cv", commit_valid, 0);
      check_val("rst2_empty", rob_empty, 1);
      check_val("rst2_atag", alloc_tag, 0);
      #1;
      reset = 1'b0;
      tick();

      // Fill to 16 entries; entry 5 is a branch
      for (int i = 0; i < ROB_SIZE; i++) begin
         set_alloc(1, (i == 5), i, i + 32, i + 64);
         #1;
         check_val($sformatf("t3_atag%0d", i), alloc_tag, i);
         tick();
      end
      check_val("t3_full", rob_full, 1);
      set_alloc(1, 0, 20, 90, 91);
      check_val("t3_atag17", alloc_tag, 0);
      tick();
      check_val("t3_full_after_drop", rob_full, 1);
      check_val("t3_tail_after_drop", alloc_tag, 0);

      // Full with writeback to head, no alloc: still full in commit cycle
      set_alloc(0, 0, 0, 0, 0);
      set_wb(1, 0); tick();
      set_wb(0, 0);
      check_val("t5_full_commit_cyc", rob_full, 1);
      check_val("t5_cv", commit_valid, 1);
      check_val("t5_crd", commit_arch_rd, 0);
      check_val("t5_cphy", commit_phy_rd, 32);
      check_val("t5_cold", commit_old_phy_rd, 64);

      // Commit and alloc together while full: alloc rejected
      set_alloc(1, 0, 30, 100, 110);
      #1;
      check_val("t5_atag_pre", alloc_tag, 0);
      tick();
      check_val("t5_full_after", rob_full, 0);
      check_val("t5_cv_after", commit_valid, 0);
      check_val("t5_tail_kept", alloc_tag, 0);

      // Wrap: the following alloc lands on tag 0
      check_val("t3_wrap_atag", alloc_tag, 0);
      tick();
      set_alloc(0, 0, 0, 0, 0);
      check_val("t3_wrap_full", rob_full, 1);
      check_val("t3_wrap_tail", alloc_tag, 1);

      // Retire tags 1..4 to bring head to the branch at tag 5
      for (int t = 1; t <= 4; t++) begin
         set_wb(1, t); tick();
         check_val($sformatf("t4_cv%0d", t), commit_valid, 1);
         check_val($sformatf("t4_ctag%0d", t), commited_branch_tag, t);
      end
      set_wb(0, 0); tick();
      check_val("t4_cv_idle", commit_valid, 0);
      check_val("t4_br_idle", commited_branch_op, 0);
      check_val("t4_head5", commited_branch_tag, 5);

      // Writeback to head together with an alloc
      set_wb(1, 5);
`ifndef ROB_EXCEPTION_EN
      wb_exception = 1'b1;
`endif
      set_alloc(1, 0, 31, 101, 111);
      #1;
      check_val("t4_atag_pre", alloc_tag, 1);
      tick();
      set_wb(0, 0);
      wb_exception = 1'b0;
      set_alloc(0, 0, 0, 0, 0);
      check_val("t4_cv", commit_valid, 1);
      check_val("t4_br", commited_branch_op, 1);
      check_val("t4_btag", commited_branch_tag, 5);
      check_val("t4_crd", commit_arch_rd, 5);
      check_val("t4_cphy", commit_phy_rd, 37);
      check_val("t4_cold", commit_old_phy_rd, 69);
      check_val("t4_cexc", commit_exception, 0);
      check_val("t4_atag_post", alloc_tag, 2);
      tick();
      check_val("t4_cv_next", commit_valid, 0);
      check_val("t4_br_next", commited_branch_op, 0);
      check_val("t4_btag_next", commited_branch_tag, 6);

`ifdef ROB_EXCEPTION_EN
      // Faulting head flushes four live entries
      reset = 1'b1;
      #1;
      reset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         set_alloc(1, 0, i + 1, i + 40, i + 50);
         tick();
      end
      set_alloc(0, 0, 0, 0, 0);
      set_wb(1, 0);
      wb_exception = 1'b1;
      tick();
      set_wb(0, 0);
      wb_exception = 1'b0;
      set_alloc(1, 0, 7, 77, 78);
      check_val("t6_cexc", commit_exception, 1);
      check_val("t6_cv", commit_valid, 0);
      tick();
      set_alloc(0, 0, 0, 0, 0);
      check_val("t6_cexc_next", commit_exception, 0);
      check_val("t6_empty", rob_empty, 1);
      check_val("t6_atag", alloc_tag, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
